// File: rtl/conveyor_writeback_arbiter.sv
// Round-robin arbiter sharing the conveyor slot-write port among completing pipelines,
// with per-conveyor outstanding-result counters that report when each conveyor has drained.
module conveyor_writeback_arbiter #(
  parameter int unsigned WORD_WIDTH          = 32,
  parameter int unsigned CONVEYOR_ADDR_WIDTH = 4,
  parameter int unsigned NUM_REQ             = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  input  logic [NUM_REQ-1:0]                     req_conveyor_i,
  input  logic [NUM_REQ*CONVEYOR_ADDR_WIDTH-1:0] req_slot_i,
  input  logic [NUM_REQ*3-1:0]                   req_fault_i,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]          req_value_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic                                   wr_block_i,
  input  logic                                   alloc_valid_i,
  input  logic                                   alloc_conveyor_i,
  output logic                                   wr_en_o,
  output logic                                   wr_conveyor_o,
  output logic [CONVEYOR_ADDR_WIDTH-1:0]         wr_slot_o,
  output logic [WORD_WIDTH+3:0]                  wr_data_o,
  output logic [1:0]                             drained_o,
  output logic                                   err_o
);

  localparam int unsigned FAULT_ADDR_WIDTH = 3;
  localparam int unsigned SLOT_WIDTH       = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH;
  localparam int unsigned CNT_WIDTH        = CONVEYOR_ADDR_WIDTH + 1;
  localparam int unsigned CONVEYOR_SIZE    = 1 << CONVEYOR_ADDR_WIDTH;
  localparam int unsigned PTR_WIDTH        = $clog2(NUM_REQ);

  logic [PTR_WIDTH-1:0]              rr_ptr_q, rr_ptr_d;
  logic [1:0][CNT_WIDTH-1:0]         pending_q, pending_d;
  logic                              err_q, err_d;
  logic                              wr_en_q, wr_en_d;
  logic                              wr_conveyor_q, wr_conveyor_d;
  logic [CONVEYOR_ADDR_WIDTH-1:0]    wr_slot_q, wr_slot_d;
  logic [SLOT_WIDTH-1:0]             wr_data_q, wr_data_d;

  logic [PTR_WIDTH-1:0]              grant_idx;
  logic [PTR_WIDTH-1:0]              scan_idx;
  logic [31:0]                       scan_sum;
  logic                              xfer;
  logic                              sel_conveyor;
  logic [CONVEYOR_ADDR_WIDTH-1:0]    sel_slot;
  logic [FAULT_ADDR_WIDTH-1:0]       sel_fault;
  logic [WORD_WIDTH-1:0]             sel_value;

  // Scan upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    req_ready_o = '0;
    grant_idx   = '0;
    scan_idx    = '0;
    scan_sum    = '0;
    xfer        = 1'b0;
    if (!wr_block_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_sum = 32'(rr_ptr_q) + k;
        if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
        scan_idx = PTR_WIDTH'(scan_sum);
        if (!xfer && req_valid_i[scan_idx]) begin
          xfer                  = 1'b1;
          req_ready_o[scan_idx] = 1'b1;
          grant_idx             = scan_idx;
        end
      end
    end
  end

  always_comb begin
    sel_conveyor = req_conveyor_i[grant_idx];
    sel_slot     = req_slot_i[32'(grant_idx)*CONVEYOR_ADDR_WIDTH +: CONVEYOR_ADDR_WIDTH];
    sel_fault    = req_fault_i[32'(grant_idx)*FAULT_ADDR_WIDTH +: FAULT_ADDR_WIDTH];
    sel_value    = req_value_i[32'(grant_idx)*WORD_WIDTH +: WORD_WIDTH];
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    wr_en_d       = xfer;
    wr_conveyor_d = wr_conveyor_q;
    wr_slot_d     = wr_slot_q;
    wr_data_d     = wr_data_q;
    if (xfer) begin
      rr_ptr_d      = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      wr_conveyor_d = sel_conveyor;
      wr_slot_d     = sel_slot;
      wr_data_d     = {1'b1, sel_fault, sel_value};
    end
  end

  // A simultaneous alloc and transfer on one conveyor cancel out, so neither can violate.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    for (int c = 0; c < 2; c++) begin
      logic inc, dec;
      inc = alloc_valid_i && (alloc_conveyor_i == 1'(c));
      dec = xfer && (sel_conveyor == 1'(c));
      if (inc && !dec) begin
        if (pending_q[c] == CNT_WIDTH'(CONVEYOR_SIZE)) err_d = 1'b1;
        else pending_d[c] = pending_q[c] + 1'b1;
      end else if (dec && !inc) begin
        if (pending_q[c] == '0) err_d = 1'b1;
        else pending_d[c] = pending_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q      <= '0;
      pending_q     <= '0;
      err_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_conveyor_q <= 1'b0;
      wr_slot_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      pending_q     <= pending_d;
      err_q         <= err_d;
      wr_en_q       <= wr_en_d;
      wr_conveyor_q <= wr_conveyor_d;
      wr_slot_q     <= wr_slot_d;
      wr_data_q     <= wr_data_d;
    end
  end

  always_comb begin
    wr_en_o       = wr_en_q;
    wr_conveyor_o = wr_conveyor_q;
    wr_slot_o     = wr_slot_q;
    wr_data_o     = wr_data_q;
    err_o         = err_q;
    for (int c = 0; c < 2; c++) begin
      drained_o[c] = (pending_q[c] == '0) && !(wr_en_q && (wr_conveyor_q == 1'(c)));
    end
  end

endmodule

// File: tb/tb_conveyor_writeback_arbiter.sv
// Directed plus randomized checks of conveyor_writeback_arbiter against a transaction-level
// model of its grant, write-stage and outstanding-counter rules.
module tb_conveyor_writeback_arbiter;

  localparam int N  = 4;
  localparam int CAW = 4;
  localparam int WW = 32;
  localparam int SIZE = 1 << CAW;
  localparam logic [2:0] F_NONE = 3'd0;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_conveyor = '0;
  logic [N*CAW-1:0]  req_slot = '0;
  logic [N*3-1:0]    req_fault = '0;
  logic [N*WW-1:0]   req_value = '0;
  logic [N-1:0]      req_ready;
  logic              wr_block = 1'b0;
  logic              alloc_valid = 1'b0;
  logic              alloc_conveyor = 1'b0;
  logic              wr_en;
  logic              wr_conveyor;
  logic [CAW-1:0]    wr_slot;
  logic [WW+3:0]     wr_data;
  logic [1:0]        drained;
  logic              err;

  always #5 clk = ~clk;

  conveyor_writeback_arbiter #(
    .WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(CAW), .NUM_REQ(N)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_conveyor_i(req_conveyor), .req_slot_i(req_slot),
    .req_fault_i(req_fault), .req_value_i(req_value), .req_ready_o(req_ready),
    .wr_block_i(wr_block), .alloc_valid_i(alloc_valid), .alloc_conveyor_i(alloc_conveyor),
    .wr_en_o(wr_en), .wr_conveyor_o(wr_conveyor), .wr_slot_o(wr_slot), .wr_data_o(wr_data),
    .drained_o(drained), .err_o(err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Requesters' held results
  bit         hv[N];
  bit         hc[N];
  logic [3:0] hs[N];
  logic [2:0] hf[N];
  logic [31:0] hval[N];

  // Reference model state
  int          m_rr;
  int          m_pend[2];
  bit          m_err;
  bit          m_we;
  bit          m_conv;
  logic [3:0]  m_slot;
  logic [35:0] m_data;
  int          last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_pend[0] = 0; m_pend[1] = 0; m_err = 0;
    m_we = 0; m_conv = 0; m_slot = '0; m_data = '0; last_grant = -1;
  endtask

  task automatic new_req(input int i);
    hv[i] = 1; hc[i] = 1'($urandom); hs[i] = 4'($urandom);
    hf[i] = 3'($urandom); hval[i] = $urandom;
  endtask

  task automatic set_req(input int i, input bit c, input logic [3:0] s,
                         input logic [2:0] f, input logic [31:0] v);
    hv[i] = 1; hc[i] = c; hs[i] = s; hf[i] = f; hval[i] = v;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) hv[i] = 0;
  endtask

  // One clock cycle: drive, check grant, advance the model, check registered outputs.
  task automatic step(input bit blk, input bit av, input bit ac);
    int g;
    logic [1:0] exp_dr;
    wr_block = blk; alloc_valid = av; alloc_conveyor = ac;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = hv[i];
      req_conveyor[i] = hc[i];
      req_slot[i*CAW +: CAW] = hs[i];
      req_fault[i*3 +: 3] = hf[i];
      req_value[i*WW +: WW] = hval[i];
    end
    #1;
    g = -1;
    if (!blk) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && hv[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
    for (int c = 0; c < 2; c++) begin
      bit inc, dec;
      inc = av && (ac == c);
      dec = (g >= 0) && (hc[g] == c);
      if (inc && !dec) begin
        if (m_pend[c] == SIZE) m_err = 1; else m_pend[c]++;
      end else if (dec && !inc) begin
        if (m_pend[c] == 0) m_err = 1; else m_pend[c]--;
      end
    end
    last_grant = g;
    if (g >= 0) begin
      m_we = 1; m_conv = hc[g]; m_slot = hs[g]; m_data = {1'b1, hf[g], hval[g]};
      m_rr = (g + 1) % N; hv[g] = 0;
    end else begin
      m_we = 0;
    end
    @(posedge clk); #1;
    chk("wr_en", 64'(wr_en), 64'(m_we));
    chk("wr_conveyor", 64'(wr_conveyor), 64'(m_conv));
    chk("wr_slot", 64'(wr_slot), 64'(m_slot));
    chk("wr_data", 64'(wr_data), 64'(m_data));
    exp_dr[0] = (m_pend[0] == 0) && !(m_we && m_conv == 0);
    exp_dr[1] = (m_pend[1] == 0) && !(m_we && m_conv == 1);
    chk("drained", 64'(drained), 64'(exp_dr));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    clear_reqs();
    req_valid = '0; alloc_valid = 0; wr_block = 0;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_drained", 64'(drained), 64'(2'b11));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(posedge clk); #1;
    reset_i = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_reqs();
    do_reset();

    // Reset mid-write: grant req0 (rr moves to 1), then reset while the write is registered.
    set_req(0, 0, 4'h3, F_NONE, 32'h1234_5678);
    step(0, 0, 0);
    chk("t1_wr_en_before_rst", 64'(wr_en), 64'(1));
    do_reset();
    for (int i = 0; i < N; i++) new_req(i);
    step(0, 0, 0);
    chk("t1_grant_after_rst", 64'(last_grant), 64'(0));

    // Round-robin with all requesters held valid.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < N; i++) if (!hv[i]) new_req(i);
      step(0, 0, 0);
      chk("t2_rr_order", 64'(last_grant), 64'(n % N));
    end

    // Block: req2 waits out three blocked cycles, then wins immediately.
    do_reset();
    new_req(2);
    for (int n = 0; n < 3; n++) step(1, 0, 0);
    step(0, 0, 0);
    chk("t3_grant_after_block", 64'(last_grant), 64'(2));

    // Data path.
    do_reset();
    set_req(1, 1, 4'hF, F_NONE, 32'hDEAD_BEEF);
    step(0, 1, 1);
    chk("t4_wr_data_lit", 64'(wr_data), 64'({1'b1, F_NONE, 32'hDEAD_BEEF}));

    // Counters on conveyor 0.
    do_reset();
    for (int n = 0; n < 3; n++) step(0, 1, 0);
    set_req(0, 0, 4'h1, F_NONE, 32'h11); step(0, 0, 0);
    set_req(1, 0, 4'h2, F_NONE, 32'h22); step(0, 1, 0);
    set_req(2, 0, 4'h3, F_NONE, 32'h33); step(0, 0, 0);
    set_req(3, 0, 4'h4, F_NONE, 32'h44); step(0, 0, 0);
    chk("t5_not_drained_in_flight", 64'(drained[0]), 64'(0));
    step(0, 0, 0);
    chk("t5_drained_after_write", 64'(drained[0]), 64'(1));

    // Violations: underflow, then overflow.
    do_reset();
    set_req(3, 1, 4'h9, 3'd5, 32'hCAFE_F00D);
    step(0, 0, 0);
    chk("t6_underflow_err", 64'(err), 64'(1));
    do_reset();
    for (int n = 0; n < 17; n++) step(0, 1, 0);
    chk("t6_overflow_err", 64'(err), 64'(1));

    // Randomized traffic; allocs lean ahead of completions to keep counters busy.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) if (!hv[i] && $urandom_range(0, 3) == 0) new_req(i);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 1'($urandom));
      if (n == 200) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
